// File: rtl/sram_bus_responder.sv
// sram_bus_responder: SRAM-bus slave serving block RAM plus an LED/button/cycle-counter MMIO page.
module sram_bus_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_cs_n,
    input  logic        sram_rd_n,
    input  logic        sram_wr_n,
    input  logic [15:0] sram_addr,
    input  logic [15:0] sram_wdata,
    output logic [15:0] sram_rdata,
    output logic        rd_valid,
    input  logic        button,
    output logic        led,
    output logic        bus_err
);
    localparam logic [15:0] BTN_A = MMIO_BASE + 16'd1;
    localparam logic [15:0] CNT_A = MMIO_BASE + 16'd2;

    logic        w_wr_act, w_rd_act, w_conflict, w_commit, w_commit_ram, w_commit_led, w_led_next;
    logic [15:0] w_ram_rd, w_rd_data;
    logic        r_wr_prev, r_led, r_bus_err, r_sync1, r_sync2, r_rd_valid;
    logic [15:0] r_pend_addr, r_pend_data, r_cnt, r_rdata;
    logic [15:0] r_mem [2**ADDR_W];

    assign w_wr_act     = ~sram_cs_n & ~sram_wr_n;
    assign w_rd_act     = ~sram_cs_n & ~sram_rd_n & sram_wr_n;
    assign w_conflict   = ~sram_cs_n & ~sram_rd_n & ~sram_wr_n;
    // Commit on the trailing edge of the write strobe; rst discards the pending write.
    assign w_commit     = r_wr_prev & ~w_wr_act & ~rst;
    assign w_commit_ram = w_commit & (r_pend_addr[15:ADDR_W] == '0);
    assign w_commit_led = w_commit & (r_pend_addr == MMIO_BASE);
    assign w_led_next   = w_commit_led ? r_pend_data[0] : r_led;
    assign w_ram_rd     = (w_commit_ram && r_pend_addr == sram_addr) ? r_pend_data
                                                                     : r_mem[sram_addr[ADDR_W-1:0]];
    assign w_rd_data    = (sram_addr[15:ADDR_W] == '0) ? w_ram_rd :
                          (sram_addr == MMIO_BASE)     ? {15'b0, w_led_next} :
                          (sram_addr == BTN_A)         ? {15'b0, r_sync2} :
                          (sram_addr == CNT_A)         ? r_cnt : 16'h0000;

    always_ff @(posedge clk)
        if (w_commit_ram) r_mem[r_pend_addr[ADDR_W-1:0]] <= r_pend_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_prev   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_led       <= 1'b0;
            r_bus_err   <= 1'b0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_cnt       <= '0;
            r_rd_valid  <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_wr_prev <= w_wr_act;
            if (w_wr_act) begin
                r_pend_addr <= sram_addr;
                r_pend_data <= sram_wdata;
            end
            r_led      <= w_led_next;
            r_bus_err  <= r_bus_err | w_conflict;
            r_sync1    <= button;
            r_sync2    <= r_sync1;
            r_cnt      <= r_cnt + 16'd1;
            r_rd_valid <= w_rd_act;
            if (w_rd_act) r_rdata <= w_rd_data;
        end
    end

    assign sram_rdata = r_rdata;
    assign rd_valid   = r_rd_valid;
    assign led        = r_led;
    assign bus_err    = r_bus_err;
endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder: directed checks of RAM, bypass, MMIO, conflict, reset and counter wrap.
module tb_sram_bus_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, button = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic [15:0] rdata;
    logic        rd_valid, led, bus_err;
    int          checks = 0, failures = 0;
    logic [15:0] v;

    sram_bus_responder dut (
        .clk(clk), .rst(rst), .sram_cs_n(cs_n), .sram_rd_n(rd_n), .sram_wr_n(wr_n),
        .sram_addr(addr), .sram_wdata(wdata), .sram_rdata(rdata), .rd_valid(rd_valid),
        .button(button), .led(led), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic c, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        cs_n = c; rd_n = r; wr_n = w; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(); bus(1'b1, 1'b1, 1'b1, 16'h0, 16'h0); endtask
    task automatic wr(input logic [15:0] a, input logic [15:0] d); bus(1'b0, 1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [15:0] a); bus(1'b0, 1'b0, 1'b1, a, 16'h0); endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        checks += 4;
        if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        if (led !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", led); end
        if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_err); end
        rst = 1'b0;
        rd(16'hFF02);
        checks += 2;
        if (rdata !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", rdata); end
        if (rd_valid !== 1'b1) begin failures++; $display("FAIL reset_cnt_valid got=%b exp=1", rd_valid); end
    endtask

    task automatic test_write_read();
        repeat (3) wr(16'h0010, 16'hBEEF);
        idle();
        rd(16'h0010);
        checks += 2;
        if (rdata !== 16'hBEEF) begin failures++; $display("FAIL wr_rd_data got=%h exp=beef", rdata); end
        if (rd_valid !== 1'b1) begin failures++; $display("FAIL wr_rd_valid got=%b exp=1", rd_valid); end
        idle();
        checks += 2;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", rd_valid); end
        if (rdata !== 16'hBEEF) begin failures++; $display("FAIL idle_hold got=%h exp=beef", rdata); end
        bus(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0);
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL cs_only_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_bypass();
        wr(16'h0010, 16'h1234);
        rd(16'h0010);
        checks++;
        if (rdata !== 16'h1234) begin failures++; $display("FAIL bypass got=%h exp=1234", rdata); end
        repeat (2) wr(16'h0011, 16'hAAAA);
        wr(16'h0011, 16'h5555);
        idle();
        rd(16'h0011);
        checks++;
        if (rdata !== 16'h5555) begin failures++; $display("FAIL held_write got=%h exp=5555", rdata); end
        wr(16'h0012, 16'h7777);
        rd(16'h0010);
        checks++;
        if (rdata !== 16'h1234) begin failures++; $display("FAIL wr_then_rd_other got=%h exp=1234", rdata); end
        rd(16'h0012);
        checks++;
        if (rdata !== 16'h7777) begin failures++; $display("FAIL commit_during_rd got=%h exp=7777", rdata); end
    endtask

    task automatic test_mmio();
        wr(16'hFF00, 16'h0003);
        idle();
        checks++;
        if (led !== 1'b1) begin failures++; $display("FAIL led_set got=%b exp=1", led); end
        rd(16'hFF00);
        checks++;
        if (rdata !== 16'h0001) begin failures++; $display("FAIL led_read got=%h exp=0001", rdata); end
        wr(16'hFF00, 16'h0000);
        rd(16'hFF00);
        checks += 2;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL led_bypass got=%h exp=0000", rdata); end
        if (led !== 1'b0) begin failures++; $display("FAIL led_clear got=%b exp=0", led); end
        wr(16'hFF00, 16'h0001);
        idle();
        button = 1'b1;
        idle();
        idle();
        rd(16'hFF01);
        checks++;
        if (rdata !== 16'h0001) begin failures++; $display("FAIL button_high got=%h exp=0001", rdata); end
        button = 1'b0;
        rd(16'hFF01);
        checks++;
        if (rdata !== 16'h0001) begin failures++; $display("FAIL button_lag got=%h exp=0001", rdata); end
        rd(16'hFF01);
        rd(16'hFF01);
        checks++;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL button_low got=%h exp=0000", rdata); end
        rd(16'hFF02);
        v = rdata;
        rd(16'hFF02);
        checks++;
        if (rdata !== v + 16'd1) begin failures++; $display("FAIL cnt_step got=%h exp=%h", rdata, v + 16'd1); end
        v = rdata;
        wr(16'hFF02, 16'h0000);
        idle();
        rd(16'hFF02);
        checks++;
        if (rdata !== v + 16'd3) begin failures++; $display("FAIL cnt_ro got=%h exp=%h", rdata, v + 16'd3); end
    endtask

    task automatic test_unmapped();
        wr(16'h0000, 16'h1111);
        idle();
        rd(16'h8000);
        checks += 2;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL unmapped_rd got=%h exp=0000", rdata); end
        if (rd_valid !== 1'b1) begin failures++; $display("FAIL unmapped_valid got=%b exp=1", rd_valid); end
        wr(16'h8000, 16'h5A5A);
        idle();
        rd(16'h0000);
        checks++;
        if (rdata !== 16'h1111) begin failures++; $display("FAIL unmapped_alias got=%h exp=1111", rdata); end
        rd(16'h8000);
        checks += 2;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL unmapped_wr got=%h exp=0000", rdata); end
        if (bus_err !== 1'b0) begin failures++; $display("FAIL unmapped_err got=%b exp=0", bus_err); end
    endtask

    task automatic test_conflict();
        bus(1'b0, 1'b0, 1'b0, 16'h0030, 16'h3333);
        checks += 2;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL conflict_valid got=%b exp=0", rd_valid); end
        if (bus_err !== 1'b1) begin failures++; $display("FAIL conflict_err got=%b exp=1", bus_err); end
        idle();
        rd(16'h0030);
        checks++;
        if (rdata !== 16'h3333) begin failures++; $display("FAIL conflict_commit got=%h exp=3333", rdata); end
        repeat (3) idle();
        checks++;
        if (bus_err !== 1'b1) begin failures++; $display("FAIL conflict_sticky got=%b exp=1", bus_err); end
    endtask

    task automatic test_reset_mid_write();
        wr(16'h0020, 16'h0F0F);
        idle();
        rd(16'h0020);
        checks++;
        if (rdata !== 16'h0F0F) begin failures++; $display("FAIL prior_value got=%h exp=0f0f", rdata); end
        wr(16'h0020, 16'hCAFE);
        rst = 1'b1;
        wr(16'h0020, 16'hCAFE);
        checks += 4;
        if (rdata !== 16'h0) begin failures++; $display("FAIL midrst_rdata got=%h exp=0000", rdata); end
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", rd_valid); end
        if (led !== 1'b0) begin failures++; $display("FAIL midrst_led got=%b exp=0", led); end
        if (bus_err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", bus_err); end
        rst = 1'b0;
        idle();
        rd(16'h0020);
        checks++;
        if (rdata !== 16'h0F0F) begin failures++; $display("FAIL midrst_discard got=%h exp=0f0f", rdata); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        rd(16'hFF02);
        checks++;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL wrap_start got=%h exp=0000", rdata); end
        repeat (65534) idle();
        rd(16'hFF02);
        checks++;
        if (rdata !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h exp=ffff", rdata); end
        rd(16'hFF02);
        checks++;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", rdata); end
        rd(16'hFF02);
        checks++;
        if (rdata !== 16'h0001) begin failures++; $display("FAIL wrap_one got=%h exp=0001", rdata); end
    endtask

    initial begin
        repeat (2) idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_mmio();
        test_unmapped();
        test_conflict();
        test_reset_mid_write();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
